// File: rtl/mm_result_drain_if.sv
// Row output port of mm_result_drain: a valid/ready stream of complete result rows.
// Transfer rule: a row moves when out_val && out_rdy on a rising clk edge; while out_val=1 and out_rdy=0 the producer holds out_row/out_data.
interface mm_result_drain_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int COL_NUM        = 32,
  parameter int ROW_ADDR_WIDTH = 5
);
  logic                          out_val;
  logic                          out_rdy;
  logic [DATA_WIDTH*COL_NUM-1:0] out_data;
  logic [ROW_ADDR_WIDTH-1:0]     out_row;

  modport master (
    output out_val,
    output out_data,
    output out_row,
    input  out_rdy
  );

  modport slave (
    input  out_val,
    input  out_data,
    input  out_row,
    output out_rdy
  );
endinterface

// File: rtl/mm_result_drain.sv
// Collects per-column matrix-multiply result writes into column banks and streams complete rows in order.
// Optional macro MM_DRAIN_RELU_EN: clamps negative output elements to zero on the output path.
module mm_result_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 32,
  parameter int COL_NUM    = 32,
  localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH*COL_NUM-1:0]     row_data_in,
  input  logic [ROW_ADDR_WIDTH*COL_NUM-1:0] row_wraddr,
  input  logic [COL_NUM-1:0]                row_wr_en,
  mm_result_drain_if.master                 out_port,
  output logic                              done,
  output logic                              overflow,
  output logic [1:0]                        state_dbg
);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;

  localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(ROW_NUM - 1);

  logic [1:0]                         state_q, state_nxt;
  logic [ROW_ADDR_WIDTH-1:0]          ptr_q, ptr_nxt;
  logic [ROW_NUM-1:0][COL_NUM-1:0]    mask_q, mask_nxt;
  logic                               overflow_q;
  logic                               ovf_hit;
  logic                               hs;
  logic [DATA_WIDTH*COL_NUM-1:0]      out_data_c;

  assign hs = (state_q == ST_SEND) && out_port.out_rdy;

  // Clear of the drained row is applied first so a same-cycle write re-sets its bit.
  always_comb begin
    mask_nxt = mask_q;
    ovf_hit  = 1'b0;
    if (hs) begin
      mask_nxt[ptr_q] = '0;
    end
    for (int c = 0; c < COL_NUM; c++) begin
      if (row_wr_en[c]) begin
        if (mask_q[row_wraddr[c*ROW_ADDR_WIDTH +: ROW_ADDR_WIDTH]][c]) begin
          ovf_hit = 1'b1;
        end
        mask_nxt[row_wraddr[c*ROW_ADDR_WIDTH +: ROW_ADDR_WIDTH]][c] = 1'b1;
      end
    end
  end

  // WAIT looks at the next mask so out_val rises the cycle after the completing write.
  always_comb begin
    state_nxt = state_q;
    ptr_nxt   = ptr_q;
    case (state_q)
      ST_WAIT: begin
        if (&mask_nxt[ptr_q]) begin
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (ptr_q == LAST_ROW) begin
            ptr_nxt   = '0;
            state_nxt = ST_LAST;
          end else begin
            ptr_nxt   = ptr_q + 1'b1;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_LAST: begin
        state_nxt = ST_WAIT;
      end
      default: begin
        state_nxt = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_WAIT;
      ptr_q      <= '0;
      mask_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      ptr_q      <= ptr_nxt;
      mask_q     <= mask_nxt;
      overflow_q <= overflow_q | ovf_hit;
    end
  end

  // One storage bank per column; each column writes its own row independently.
  for (genvar c = 0; c < COL_NUM; c++) begin : g_col
    logic [DATA_WIDTH-1:0]     bank [ROW_NUM];
    logic [ROW_ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0]     rd;

    assign wa = row_wraddr[c*ROW_ADDR_WIDTH +: ROW_ADDR_WIDTH];

    always_ff @(posedge clk) begin
      if (row_wr_en[c]) begin
        bank[wa] <= row_data_in[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign rd = bank[ptr_q];

`ifdef MM_DRAIN_RELU_EN
    assign out_data_c[c*DATA_WIDTH +: DATA_WIDTH] = rd[DATA_WIDTH-1] ? '0 : rd;
`else
    assign out_data_c[c*DATA_WIDTH +: DATA_WIDTH] = rd;
`endif
  end

  assign out_port.out_val  = (state_q == ST_SEND);
  assign out_port.out_row  = ptr_q;
  assign out_port.out_data = out_data_c;
  assign done              = (state_q == ST_LAST);
  assign overflow          = overflow_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_mm_result_drain.sv
// Directed bench for mm_result_drain with DATA_WIDTH=8, ROW_NUM=4, COL_NUM=4.
module tb_mm_result_drain;
  localparam int DW  = 8;
  localparam int RN  = 4;
  localparam int CN  = 4;
  localparam int RAW = 2;

  logic             clk;
  logic             reset;
  logic [DW*CN-1:0] row_data_in;
  logic [RAW*CN-1:0] row_wraddr;
  logic [CN-1:0]    row_wr_en;
  logic             done;
  logic             overflow;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  mm_result_drain_if #(.DATA_WIDTH(DW), .COL_NUM(CN), .ROW_ADDR_WIDTH(RAW)) bus ();

  mm_result_drain #(.DATA_WIDTH(DW), .ROW_NUM(RN), .COL_NUM(CN)) dut (
    .clk         (clk),
    .reset       (reset),
    .row_data_in (row_data_in),
    .row_wraddr  (row_wraddr),
    .row_wr_en   (row_wr_en),
    .out_port    (bus),
    .done        (done),
    .overflow    (overflow),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] pat(input int r);
    pat = {8'(4*r+4), 8'(4*r+3), 8'(4*r+2), 8'(4*r+1)};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.out_rdy = 1'b0;
    row_wr_en   = '0;
    reset       = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic write_row(input int r, input logic [31:0] d);
    row_data_in = d;
    row_wraddr  = {4{2'(r)}};
    row_wr_en   = 4'hF;
    tick();
    row_wr_en   = '0;
  endtask

  task automatic write_col(input int c, input int r, input logic [7:0] d);
    row_data_in            = '0;
    row_wraddr             = '0;
    row_data_in[c*8 +: 8]  = d;
    row_wraddr[c*2 +: 2]   = 2'(r);
    row_wr_en              = 4'(1 << c);
    tick();
    row_wr_en              = '0;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    bus.out_rdy = 1'b0;
    row_wr_en   = '0;
    row_data_in = '0;
    row_wraddr  = '0;
    tick();
    n_checks++; if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL reset_out_val got=%b exp=0", bus.out_val); end
    n_checks++; if (bus.out_row !== 2'd0) begin n_fail++; $display("FAIL reset_out_row got=%0d exp=0", bus.out_row); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    reset = 1'b1;
    tick();
    n_checks++; if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL reset_idle_val got=%b exp=0", bus.out_val); end
  endtask

  task automatic test_single_row();
    do_reset();
    bus.out_rdy = 1'b1;
    write_row(0, 32'h04030201);
    n_checks++; if (bus.out_val !== 1'b1) begin n_fail++; $display("FAIL single_val got=%b exp=1", bus.out_val); end
    n_checks++; if (bus.out_row !== 2'd0) begin n_fail++; $display("FAIL single_row got=%0d exp=0", bus.out_row); end
    n_checks++; if (bus.out_data !== 32'h04030201) begin n_fail++; $display("FAIL single_data got=%h exp=04030201", bus.out_data); end
    tick();
    n_checks++; if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL single_val_after got=%b exp=0", bus.out_val); end
    n_checks++; if (bus.out_row !== 2'd1) begin n_fail++; $display("FAIL single_ptr_after got=%0d exp=1", bus.out_row); end
  endtask

  task automatic test_back_to_back();
    int  exp_row;
    logic hs_prev;
    do_reset();
    bus.out_rdy = 1'b1;
    write_row(3, pat(3));
    write_row(2, pat(2));
    write_row(1, pat(1));
    n_checks++; if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL b2b_hold_val got=%b exp=0", bus.out_val); end
    write_row(0, pat(0));
    exp_row = 0;
    hs_prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_checks++; if (done !== hs_prev) begin n_fail++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", i, done, hs_prev); end
      hs_prev = bus.out_val && bus.out_rdy && (exp_row == 3);
      if (bus.out_val) begin
        n_checks++; if (bus.out_row !== 2'(exp_row)) begin n_fail++; $display("FAIL b2b_row got=%0d exp=%0d", bus.out_row, exp_row); end
        n_checks++; if (bus.out_data !== pat(exp_row)) begin n_fail++; $display("FAIL b2b_data got=%h exp=%h", bus.out_data, pat(exp_row)); end
        exp_row++;
      end
      tick();
    end
    n_checks++; if (exp_row !== 4) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4", exp_row); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_backpressure();
    do_reset();
    write_row(0, pat(0));
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.out_val !== 1'b1) begin n_fail++; $display("FAIL bp_val cyc=%0d got=%b exp=1", i, bus.out_val); end
      n_checks++; if (bus.out_data !== pat(0)) begin n_fail++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, bus.out_data, pat(0)); end
      n_checks++; if (bus.out_row !== 2'd0) begin n_fail++; $display("FAIL bp_row cyc=%0d got=%0d exp=0", i, bus.out_row); end
      tick();
    end
    bus.out_rdy = 1'b1;
    tick();
    n_checks++; if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL bp_after_val got=%b exp=0", bus.out_val); end
    n_checks++; if (bus.out_row !== 2'd1) begin n_fail++; $display("FAIL bp_after_row got=%0d exp=1", bus.out_row); end
    bus.out_rdy = 1'b0;
    write_row(1, pat(1));
    n_checks++; if (bus.out_row !== 2'd1 || bus.out_val !== 1'b1) begin n_fail++; $display("FAIL bp_next got=%0d/%b exp=1/1", bus.out_row, bus.out_val); end
    n_checks++; if (bus.out_data !== pat(1)) begin n_fail++; $display("FAIL bp_next_data got=%h exp=%h", bus.out_data, pat(1)); end
  endtask

  task automatic test_overflow();
    do_reset();
    write_col(2, 1, 8'hAA);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_first got=%b exp=0", overflow); end
    write_col(2, 1, 8'hBB);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    write_col(0, 1, 8'h11);
    write_col(1, 1, 8'h22);
    write_col(3, 1, 8'h44);
    write_row(0, pat(0));
    n_checks++; if (bus.out_row !== 2'd0 || bus.out_val !== 1'b1) begin n_fail++; $display("FAIL ovf_row0 got=%0d/%b exp=0/1", bus.out_row, bus.out_val); end
    bus.out_rdy = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.out_row !== 2'd1 || bus.out_val !== 1'b1) begin n_fail++; $display("FAIL ovf_row1 got=%0d/%b exp=1/1", bus.out_row, bus.out_val); end
    n_checks++; if (bus.out_data !== 32'h44BB2211) begin n_fail++; $display("FAIL ovf_data got=%h exp=44bb2211", bus.out_data); end
    tick();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_reset_mid_drain();
    bit reached;
    int done_cnt;
    do_reset();
    write_row(2, pat(2));
    write_row(1, pat(1));
    write_row(0, pat(0));
    write_col(0, 3, 8'h01);
    write_col(0, 3, 8'h02);
    reached = 1'b0;
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 10 && !reached; i++) begin
      tick();
      if (bus.out_val && bus.out_row == 2'd2) reached = 1'b1;
    end
    bus.out_rdy = 1'b0;
    n_checks++; if (!reached) begin n_fail++; $display("FAIL mid_reach got=0 exp=1"); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL mid_pre_ovf got=%b exp=1", overflow); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL mid_val got=%b exp=0", bus.out_val); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done got=%b exp=0", done); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_ovf got=%b exp=0", overflow); end
    n_checks++; if (bus.out_row !== 2'd0) begin n_fail++; $display("FAIL mid_row got=%0d exp=0", bus.out_row); end
    tick();
    reset = 1'b1;
    tick();
    bus.out_rdy = 1'b1;
    write_row(0, pat(0));
    n_checks++; if (bus.out_val !== 1'b1 || bus.out_row !== 2'd0) begin n_fail++; $display("FAIL mid_restart got=%b/%0d exp=1/0", bus.out_val, bus.out_row); end
    n_checks++; if (bus.out_data !== pat(0)) begin n_fail++; $display("FAIL mid_restart_data got=%h exp=%h", bus.out_data, pat(0)); end
    write_row(1, pat(1));
    write_row(2, pat(2));
    write_row(3, pat(3));
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) done_cnt++;
      tick();
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL mid_done_cnt got=%0d exp=1", done_cnt); end
    n_checks++; if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL mid_end_val got=%b exp=0", bus.out_val); end
  endtask

  task automatic test_relu();
    logic [31:0] exp_d;
`ifdef MM_DRAIN_RELU_EN
    exp_d = 32'h7F000000;
`else
    exp_d = 32'h7F00FF80;
`endif
    do_reset();
    write_row(0, 32'h7F00FF80);
    n_checks++; if (bus.out_data !== exp_d) begin n_fail++; $display("FAIL relu_data got=%h exp=%h", bus.out_data, exp_d); end
    bus.out_rdy = 1'b1;
    tick();
    n_checks++; if (bus.out_val !== 1'b0) begin n_fail++; $display("FAIL relu_after got=%b exp=0", bus.out_val); end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid_drain();
    test_relu();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
